adder_pipe: RTL and testbench

//   Parametrised, pipelined add/subtract unit with valid/ready handshakes on input and output.

---
 rtl/adder_pipe.sv | 69 ++++++
 tb/tb_adder_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract with valid/ready handshakes and per-stage carry-chain slices
module adder_pipe #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y
);
  localparam int SW = WIDTH / STAGES;
  logic adv;
  for (genvar k = 0; k < STAGES; k++) begin : g
    logic v, s, c;
    logic [WIDTH-1:0] ra, rb, rs;
    logic pv, psub, pc;
    logic [WIDTH-1:0] pa, pb, pr, nr;
    logic [SW:0] t;
    if (k == 0) begin : src
      assign pv = in_valid;
      assign psub = sub;
      assign pc = sub;
      assign pa = a;
      assign pb = b;
      assign pr = '0;
    end else begin : src
      assign pv = g[k-1].v;
      assign psub = g[k-1].s;
      assign pc = g[k-1].c;
      assign pa = g[k-1].ra;
      assign pb = g[k-1].rb;
      assign pr = g[k-1].rs;
    end
    assign t = {1'b0, pa[k*SW +: SW]} + {1'b0, pb[k*SW +: SW] ^ {SW{psub}}} + {{SW{1'b0}}, pc};
    always_comb begin
      nr = pr;
      nr[k*SW +: SW] = t[SW-1:0];
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        v <= 1'b0;
        s <= 1'b0;
        c <= 1'b0;
        ra <= '0;
        rb <= '0;
        rs <= '0;
      end else if (adv) begin
        v <= pv;
        if (pv) begin
          s <= psub;
          c <= t[SW];
          ra <= pa;
          rb <= pb;
          rs <= nr;
        end
      end
    end
  end
  assign out_valid = g[STAGES-1].v;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign y = {g[STAGES-1].s ? ~g[STAGES-1].c : g[STAGES-1].c, g[STAGES-1].rs};
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: self-checking bench for adder_pipe against a queue-based arithmetic model
module tb_adder_pipe;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] z, input logic s);
    return s ? {1'b0, x} - {1'b0, z} : {1'b0, x} + {1'b0, z};
  endfunction
  logic rst, iv, ir, sb, ov, ordy;
  logic [7:0] a, b;
  logic [8:0] y;
  adder_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .sub(sb),
    .out_valid(ov), .out_ready(ordy), .y(y)
  );
  logic [8:0] q[$];
  logic held = 0;
  logic [8:0] py = '0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 0;
    end else begin
      if (held) begin
        chk("stall_valid", {31'b0, ov}, 1);
        chk("stall_y", {23'b0, y}, {23'b0, py});
      end
      chk("in_ready_rule", {31'b0, ir}, {31'b0, !ov || ordy});
      if (ov) begin
        chk("output_expected", {31'b0, q.size() != 0}, 1);
        if (q.size() != 0) begin
          chk("y_vs_model", {23'b0, y}, {23'b0, q[0]});
          if (ordy) void'(q.pop_front());
        end
      end
      if (iv && ir) q.push_back(ref8(a, b, sb));
      held = ov && !ordy;
      py = y;
    end
  end
  task automatic single(input logic [7:0] xa, input logic [7:0] xb, input logic xs, input logic [8:0] e, input string n);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      iv = (i == 0);
      a = xa;
      b = xb;
      sb = xs;
      @(negedge clk);
      chk({n, "_valid_timing"}, {31'b0, ov}, {31'b0, i == 2});
      if (i == 2) chk(n, {23'b0, y}, {23'b0, e});
    end
  endtask
  for (genvar i = 0; i < 2; i++) begin : u
    localparam int W = i == 0 ? 16 : 8;
    localparam int S = i == 0 ? 4 : 1;
    localparam logic [W-1:0] LA = i == 0 ? W'(1) : W'(200);
    localparam logic [W-1:0] LB = i == 0 ? W'(2) : W'(100);
    localparam logic LS = i == 0;
    localparam logic [W:0] LIT = i == 0 ? (W+1)'('h1FFFF) : (W+1)'('h12C);
    logic r, v, rdy, s, o, ordy2, done;
    logic [W-1:0] x, z;
    logic [W:0] yy;
    logic [W:0] qq[$];
    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .reset(r), .in_valid(v), .in_ready(rdy), .a(x), .b(z), .sub(s),
      .out_valid(o), .out_ready(ordy2), .y(yy)
    );
    initial begin
      done = 0;
      r = 1;
      v = 1;
      x = '0;
      z = '0;
      s = 0;
      ordy2 = 1;
      repeat (3) @(posedge clk);
      #1 r = 0;
      v = 0;
      for (int j = 0; j < S + 2; j++) begin
        @(posedge clk);
        #1;
        v = (j == 0);
        x = LA;
        z = LB;
        s = LS;
        @(negedge clk);
        chk("cfg_valid_timing", {31'b0, o}, {31'b0, j == S});
        if (j == S) chk("cfg_literal", 32'(yy), 32'(LIT));
      end
      for (int j = 0; j < 400; j++) begin
        @(posedge clk);
        #1;
        v = ($urandom % 4) != 0;
        x = W'($urandom);
        z = W'($urandom);
        s = 1'($urandom);
        ordy2 = ($urandom % 4) != 0;
      end
      @(posedge clk);
      #1 v = 0;
      ordy2 = 1;
      repeat (S + 4) @(negedge clk);
      chk("cfg_drained", 32'(qq.size()), 0);
      done = 1;
    end
    always @(negedge clk) begin
      if (r) qq.delete();
      else begin
        chk("cfg_in_ready_rule", {31'b0, rdy}, {31'b0, !o || ordy2});
        if (o) begin
          chk("cfg_output_expected", {31'b0, qq.size() != 0}, 1);
          if (qq.size() != 0) begin
            chk("cfg_y_vs_model", 32'(yy), 32'(qq[0]));
            if (ordy2) void'(qq.pop_front());
          end
        end
        if (v && rdy) qq.push_back(s ? {1'b0, x} - {1'b0, z} : {1'b0, x} + {1'b0, z});
      end
    end
  end
  initial begin
    int n;
    chk("model_pin_borrow", {23'b0, ref8(8'd2, 8'd5, 1'b1)}, 32'h1FD);
    chk("model_pin_carry", {23'b0, ref8(8'd255, 8'd255, 1'b0)}, 32'h1FE);
    rst = 1;
    iv = 1;
    a = 8'd77;
    b = 8'd5;
    sb = 0;
    ordy = 1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_valid", {31'b0, ov}, 0);
      chk("reset_y", {23'b0, y}, 0);
    end
    @(posedge clk);
    #1 rst = 0;
    iv = 0;
    @(negedge clk);
    chk("post_reset_in_ready", {31'b0, ir}, 1);
    chk("post_reset_valid", {31'b0, ov}, 0);
    single(8'd10, 8'd20, 1'b0, 9'd30, "add_10_20");
    single(8'd19, 8'd2, 1'b1, 9'd17, "sub_19_2");
    single(8'd2, 8'd5, 1'b1, 9'h1FD, "sub_borrow");
    single(8'd255, 8'd255, 1'b0, 9'h1FE, "add_carry");
    single(8'd0, 8'd0, 1'b1, 9'h000, "sub_zero");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      iv = i < 5;
      a = 8'($urandom);
      b = 8'($urandom);
      sb = i[0];
      @(negedge clk);
      chk("stream_valid_timing", {31'b0, ov}, {31'b0, i >= 2 && i <= 6});
    end
    @(posedge clk);
    #1 ordy = 0;
    iv = 1;
    n = 0;
    while (!ov && n < 10) begin
      @(posedge clk);
      #1 a = 8'($urandom);
      b = 8'($urandom);
      sb = 1'($urandom);
      n++;
    end
    chk("bp_filled", {31'b0, ov}, 1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, ir}, 0);
    end
    @(posedge clk);
    #1 ordy = 1;
    iv = 0;
    repeat (4) @(negedge clk);
    chk("bp_drained", 32'(q.size()), 0);
    chk("bp_idle", {31'b0, ov}, 0);
    @(posedge clk);
    #1 ordy = 0;
    for (int i = 0; i < 2; i++) begin
      iv = 1;
      a = 8'($urandom);
      b = 8'($urandom);
      sb = 1'($urandom);
      @(posedge clk);
      #1;
    end
    iv = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    ordy = 1;
    @(negedge clk);
    chk("midflight_reset_valid", {31'b0, ov}, 0);
    repeat (4) begin
      @(negedge clk);
      chk("midflight_dropped", {31'b0, ov}, 0);
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      iv = ($urandom % 4) != 0;
      a = 8'($urandom);
      b = 8'($urandom);
      sb = 1'($urandom);
      ordy = ($urandom % 4) != 0;
    end
    @(posedge clk);
    #1 iv = 0;
    ordy = 1;
    repeat (5) @(negedge clk);
    chk("random_drained", 32'(q.size()), 0);
    n = 0;
    while (!(u[0].done && u[1].done) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("configs_done", {31'b0, u[0].done && u[1].done}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
